// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO with occupancy level, watermark flags,
// sticky overflow/underflow, synchronous flush and a selectable read mode
// (first-word-fall-through or registered read). All outputs are registered.
module fifo_level #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             r_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [DEPTH:0]   level,
    output logic             overflow,
    output logic             underflow
);

    localparam int             N        = 1 << DEPTH;
    localparam logic [DEPTH:0] N_L      = (DEPTH+1)'(N);
    localparam logic [DEPTH:0] AFULL_L  = (DEPTH+1)'(AFULL_THRESH);
    localparam logic [DEPTH:0] AEMPTY_L = (DEPTH+1)'(AEMPTY_THRESH);
    localparam logic [DEPTH:0] ZERO_L   = (DEPTH+1)'(0);

    logic [WIDTH-1:0] mem_r [N];
    logic [DEPTH-1:0] wr_ptr_r;
    logic [DEPTH-1:0] rd_ptr_r;
    logic [DEPTH:0]   level_r;
    logic             full_r;
    logic             empty_r;
    logic             afull_r;
    logic             aempty_r;
    logic             ovf_r;
    logic             unf_r;
    logic [WIDTH-1:0] r_data_r;
    logic             r_valid_r;

    logic             r_fire_s;
    logic             w_fire_s;
    logic [DEPTH:0]   level_next_s;
    logic [DEPTH:0]   after_pop_s;
    logic [DEPTH-1:0] wr_ptr_next_s;
    logic [DEPTH-1:0] rd_ptr_next_s;
    logic [WIDTH-1:0] r_data_next_s;
    logic             r_valid_next_s;

    // Handshake qualification, next occupancy and next read-port contents.
    always_comb begin
        r_fire_s       = r_en & ~empty_r;
        w_fire_s       = w_en & (~full_r | r_en);
        level_next_s   = level_r + (DEPTH+1)'(w_fire_s) - (DEPTH+1)'(r_fire_s);
        after_pop_s    = level_r - (DEPTH+1)'(r_fire_s);
        wr_ptr_next_s  = wr_ptr_r + DEPTH'(w_fire_s);
        rd_ptr_next_s  = rd_ptr_r + DEPTH'(r_fire_s);
        r_data_next_s  = r_data_r;
        r_valid_next_s = 1'b0;
        if (FWFT != 0) begin
            // Head follows the queue; a write landing in an otherwise empty
            // queue becomes the head directly from w_data.
            if (w_fire_s && (after_pop_s == ZERO_L)) begin
                r_data_next_s = w_data;
            end else if (level_next_s != ZERO_L) begin
                r_data_next_s = mem_r[rd_ptr_next_s];
            end else begin
                r_data_next_s = r_data_r;
            end
            r_valid_next_s = (level_next_s != ZERO_L);
        end else begin
            // Registered read: capture the head only when a pop is accepted.
            if (r_fire_s) begin
                r_data_next_s = mem_r[rd_ptr_r];
            end else begin
                r_data_next_s = r_data_r;
            end
            r_valid_next_s = r_fire_s;
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge aclk) begin
        if (w_fire_s && !flush) begin
            mem_r[wr_ptr_r] <= w_data;
        end
    end

    // Pointers, level, flags and read port state, with flush as a soft clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            afull_r   <= 1'b0;
            aempty_r  <= 1'b1;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            r_data_r  <= '0;
            r_valid_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            afull_r   <= 1'b0;
            aempty_r  <= 1'b1;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            r_valid_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            level_r   <= level_next_s;
            full_r    <= (level_next_s == N_L);
            empty_r   <= (level_next_s == ZERO_L);
            afull_r   <= (level_next_s >= AFULL_L);
            aempty_r  <= (level_next_s <= AEMPTY_L);
            ovf_r     <= ovf_r | (w_en & ~w_fire_s);
            unf_r     <= unf_r | (r_en & empty_r);
            r_data_r  <= r_data_next_s;
            r_valid_r <= r_valid_next_s;
        end
    end

    assign r_data       = r_data_r;
    assign r_valid      = r_valid_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign level        = level_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level: one FWFT instance and one registered-read
// instance share the same stimulus (N=4, AFULL=3, AEMPTY=1).
`timescale 1ns/1ps
module tb_fifo_level;

    logic       aclk;
    logic       aresetn;
    logic       flush;
    logic       w_en;
    logic [7:0] w_data;
    logic       r_en;

    logic [7:0] f_r_data, g_r_data;
    logic       f_r_valid, g_r_valid;
    logic       f_full, g_full, f_empty, g_empty;
    logic       f_af, g_af, f_ae, g_ae;
    logic [2:0] f_level, g_level;
    logic       f_ovf, g_ovf, f_unf, g_unf;

    int n_chk;
    int n_pass;

    fifo_level #(.WIDTH(8), .DEPTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) u_fwft (
        .aclk(aclk), .aresetn(aresetn), .flush(flush), .w_en(w_en), .w_data(w_data),
        .r_en(r_en), .r_data(f_r_data), .r_valid(f_r_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
        .overflow(f_ovf), .underflow(f_unf)
    );

    fifo_level #(.WIDTH(8), .DEPTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)) u_reg (
        .aclk(aclk), .aresetn(aresetn), .flush(flush), .w_en(w_en), .w_data(w_data),
        .r_en(r_en), .r_data(g_r_data), .r_valid(g_r_valid), .full(g_full), .empty(g_empty),
        .almost_full(g_af), .almost_empty(g_ae), .level(g_level),
        .overflow(g_ovf), .underflow(g_unf)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock with the given request, then requests drop back to idle.
    task automatic step(input logic we, input logic [7:0] d, input logic re, input logic fl);
        w_en   = we;
        w_data = d;
        r_en   = re;
        flush  = fl;
        @(posedge aclk);
        #1;
        w_en  = 1'b0;
        r_en  = 1'b0;
        flush = 1'b0;
    endtask

    // Both instances back at reset values.
    task automatic chk_reset(input string tag);
        chk({tag, "_f_rdata"}, 32'(f_r_data), 32'h00);
        chk({tag, "_f_flags"}, {26'd0, f_r_valid, f_full, f_empty, f_af, f_ae, f_ovf}, {26'd0, 6'b001010});
        chk({tag, "_f_unf"},   32'(f_unf), 32'd0);
        chk({tag, "_f_level"}, 32'(f_level), 32'd0);
        chk({tag, "_g_rdata"}, 32'(g_r_data), 32'h00);
        chk({tag, "_g_flags"}, {26'd0, g_r_valid, g_full, g_empty, g_af, g_ae, g_ovf}, {26'd0, 6'b001010});
        chk({tag, "_g_unf"},   32'(g_unf), 32'd0);
        chk({tag, "_g_level"}, 32'(g_level), 32'd0);
    endtask

    logic [7:0] heads [4];

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        aresetn = 1'b0;
        flush   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        w_data  = 8'h00;
        repeat (2) @(posedge aclk);
        #1;
        chk_reset("rst");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Fill: level/flags after each write (almost_empty at 1, almost_full from 3).
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("w1_level", 32'(f_level), 32'd1);
        chk("w1_flags", {28'd0, f_r_valid, f_empty, f_ae, f_af}, {28'd0, 4'b1010});
        chk("w1_rdata", 32'(f_r_data), 32'h11);
        chk("w1_g_rvalid", 32'(g_r_valid), 32'd0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        chk("w2_level", 32'(f_level), 32'd2);
        chk("w2_ae_af", {30'd0, f_ae, f_af}, {30'd0, 2'b00});
        chk("w2_rdata", 32'(f_r_data), 32'h11);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("w3_af_full", {30'd0, f_af, f_full}, {30'd0, 2'b10});
        step(1'b1, 8'h44, 1'b0, 1'b0);
        chk("w4_level", 32'(f_level), 32'd4);
        chk("w4_full", 32'(f_full), 32'd1);

        // Full with simultaneous write and pop.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullrw_level", 32'(f_level), 32'd4);
        chk("fullrw_full", 32'(f_full), 32'd1);
        chk("fullrw_ovf", 32'(f_ovf), 32'd0);
        chk("fullrw_head", 32'(f_r_data), 32'h22);
        chk("fullrw_g_rdata", 32'(g_r_data), 32'h11);
        chk("fullrw_g_rvalid", 32'(g_r_valid), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_g_rvalid", 32'(g_r_valid), 32'd0);
        chk("idle_g_rdata", 32'(g_r_data), 32'h11);

        // Drain: heads in order, 0x55 last.
        heads[0] = 8'h22; heads[1] = 8'h33; heads[2] = 8'h44; heads[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_head", i), 32'(f_r_data), 32'(heads[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain%0d_level", i), 32'(f_level), 32'(3 - i));
        end
        chk("drain_empty", {30'd0, f_empty, f_r_valid}, {30'd0, 2'b10});
        chk("drain_g_last", 32'(g_r_data), 32'h55);

        // Underflow on empty.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_flag", 32'(f_unf), 32'd1);
        chk("unf_level", 32'(f_level), 32'd0);
        chk("unf_rvalid", 32'(f_r_valid), 32'd0);

        // Empty with write and read: only the write fires, bypass to r_data.
        step(1'b1, 8'h66, 1'b1, 1'b0);
        chk("emptyrw_level", 32'(f_level), 32'd1);
        chk("emptyrw_rdata", 32'(f_r_data), 32'h66);
        chk("emptyrw_unf", 32'(f_unf), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow with contents held, then flush.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("ovf_flag", 32'(f_ovf), 32'd1);
        chk("ovf_level", 32'(f_level), 32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(f_ovf), 32'd1);
        chk("ovf_head", 32'(f_r_data), 32'hA1);
        step(1'b1, 8'h88, 1'b1, 1'b1);
        chk("flush_errs", {30'd0, f_ovf, f_unf}, {30'd0, 2'b00});
        chk("flush_level", 32'(f_level), 32'd0);
        chk("flush_flags", {28'd0, f_empty, f_ae, f_full, f_r_valid}, {28'd0, 4'b1100});

        // Registered-read timing.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("reg_pre_rvalid", 32'(g_r_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("reg_t1_rdata", 32'(g_r_data), 32'hA5);
        chk("reg_t1_rvalid", 32'(g_r_valid), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("reg_t2_rvalid", 32'(g_r_valid), 32'd0);
        chk("reg_t2_rdata", 32'(g_r_data), 32'hA5);

        // Wrap: ten write/read pairs at level 1.
        step(1'b1, 8'hB0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("wrap%0d_head", i), 32'(f_r_data), 32'(8'hB0 + i - 1));
            step(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
            chk($sformatf("wrap%0d_g", i), 32'(g_r_data), 32'(8'hB0 + i - 1));
        end
        chk("wrap_level", 32'(f_level), 32'd1);

        // Asynchronous reset mid-burst.
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        w_en   = 1'b1;
        w_data = 8'hC2;
        #3;
        aresetn = 1'b0;
        #1;
        chk_reset("arst");
        w_en = 1'b0;
        #3;
        aresetn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_level", 32'(f_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
